// File: rtl/alu_result_fifo.sv
// Result buffer behind the ALU select mux: captures {result, sel} plus zero/neg
// flags on push and presents entries in order over a valid/ready handshake.
module alu_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_result,
    input  logic [2:0]               in_sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [2:0]               out_sel,
    output logic                     out_zero,
    output logic                     out_neg,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem_result [DEPTH];
    logic [2:0]       r_mem_sel    [DEPTH];
    logic             r_mem_zero   [DEPTH];
    logic             r_mem_neg    [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    function automatic logic flag_zero(input logic [WIDTH-1:0] v);
        return (v == '0);
    endfunction

    function automatic logic flag_neg(input logic [WIDTH-1:0] v);
        return v[WIDTH-1];
    endfunction

    // Handshake decoded from count alone so ready/valid never depend on the peer.
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign count     = r_count;

    assign out_result = r_mem_result[r_rd_ptr];
    assign out_sel    = r_mem_sel[r_rd_ptr];
    assign out_zero   = r_mem_zero[r_rd_ptr];
    assign out_neg    = r_mem_neg[r_rd_ptr];

    // Storage is never reset; an entry only becomes visible through count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_result[r_wr_ptr] <= in_result;
            r_mem_sel[r_wr_ptr]    <= in_sel;
            r_mem_zero[r_wr_ptr]   <= flag_zero(in_result);
            r_mem_neg[r_wr_ptr]    <= flag_neg(in_result);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Directed bench for alu_result_fifo: reset, flags, full/empty boundaries,
// pointer wrap, flush and mid-run reset, all against hand-computed values.
module tb_alu_result_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_result;
    logic [2:0]       in_sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [2:0]       out_sel;
    logic             out_zero;
    logic             out_neg;
    logic [2:0]       count;

    int n_checks = 0;
    int n_errors = 0;

    alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_sel    (out_sel),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v, input logic [2:0] s);
        in_valid  = 1'b1;
        in_result = v;
        in_sel    = s;
        step();
        in_valid  = 1'b0;
    endtask

    logic [15:0] exp_v [4];
    logic        exp_n [4];

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_result = '0; in_sel = '0;
        step(); step();
        rst_n = 1'b1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single zero-valued push
        push(16'h0000, 3'b010);
        chk("t1_count", 32'(count), 32'd1);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", 32'(out_result), 32'h0000);
        chk("t1_zero", 32'(out_zero), 32'd1);
        chk("t1_neg", 32'(out_neg), 32'd0);
        chk("t1_sel", 32'(out_sel), 32'd2);
        out_ready = 1'b1; step(); out_ready = 1'b0;
        chk("t1_drain", 32'(count), 32'd0);

        // Fill to full, fifth offer held off, then drain in order
        exp_v[0] = 16'h8001; exp_v[1] = 16'h1234; exp_v[2] = 16'hFFFF; exp_v[3] = 16'h0005;
        exp_n[0] = 1'b1; exp_n[1] = 1'b0; exp_n[2] = 1'b1; exp_n[3] = 1'b0;
        for (int i = 0; i < 4; i++) push(exp_v[i], 3'(i));
        chk("t2_full_count", 32'(count), 32'd4);
        chk("t2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; in_result = 16'h7777; in_sel = 3'd7;
        step();
        chk("t2_held_count", 32'(count), 32'd4);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t2_pop_valid", 32'(out_valid), 32'd1);
            chk("t2_pop_result", 32'(out_result), 32'(exp_v[i]));
            chk("t2_pop_neg", 32'(out_neg), 32'(exp_n[i]));
            chk("t2_pop_sel", 32'(out_sel), 32'(i));
            chk("t2_pop_zero", 32'(out_zero), 32'd0);
            step();
        end
        out_ready = 1'b0;
        chk("t2_empty_count", 32'(count), 32'd0);
        chk("t2_empty_valid", 32'(out_valid), 32'd0);

        // Streaming push/pop across pointer wraps
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            if (k > 1) begin
                chk("t3_count", 32'(count), 32'd1);
                chk("t3_result", 32'(out_result), 32'(k - 1));
            end
            in_valid = 1'b1; in_result = 16'(k); in_sel = 3'd1;
            step();
        end
        in_valid = 1'b0;
        chk("t3_last", 32'(out_result), 32'd10);
        chk("t3_last_count", 32'(count), 32'd1);
        step();
        out_ready = 1'b0;
        chk("t3_drain", 32'(count), 32'd0);

        // Full with simultaneous offer and pop: only the pop happens
        for (int i = 0; i < 4; i++) push(16'h00A1 + 16'(i), 3'd3);
        in_valid = 1'b1; in_result = 16'h0BBB; in_sel = 3'd5;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t4_count", 32'(count), 32'd3);
        chk("t4_in_ready", 32'(in_ready), 32'd1);
        chk("t4_head", 32'(out_result), 32'h00A2);
        step();
        in_valid = 1'b0;
        chk("t4_accept", 32'(count), 32'd4);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_order", 32'(out_result), 32'h00A2 + 32'(i));
            step();
        end
        chk("t4_tail", 32'(out_result), 32'h0BBB);
        chk("t4_tail_sel", 32'(out_sel), 32'd5);
        step();
        out_ready = 1'b0;
        chk("t4_drain", 32'(count), 32'd0);

        // Flush beats a concurrent push
        for (int i = 0; i < 3; i++) push(16'h0C00 + 16'(i), 3'd0);
        chk("t5_pre", 32'(count), 32'd3);
        flush = 1'b1; in_valid = 1'b1; in_result = 16'h0CCC;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_valid", 32'(out_valid), 32'd0);
        push(16'h0DDD, 3'd6);
        chk("t5_after_count", 32'(count), 32'd1);
        chk("t5_after_result", 32'(out_result), 32'h0DDD);
        out_ready = 1'b1; step(); out_ready = 1'b0;

        // Mid-run reset drops entries; later push reads back correctly
        push(16'h1111, 3'd1);
        push(16'h2222, 3'd2);
        chk("t6_pre", 32'(count), 32'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_in_ready", 32'(in_ready), 32'd1);
        chk("t6_valid", 32'(out_valid), 32'd0);
        push(16'h00FF, 3'd4);
        chk("t6_result", 32'(out_result), 32'h00FF);
        chk("t6_sel", 32'(out_sel), 32'd4);
        chk("t6_zero", 32'(out_zero), 32'd0);
        chk("t6_neg", 32'(out_neg), 32'd0);
        chk("t6_count_after", 32'(count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Output buffer that sits directly downstream of the 16-bit ALU's 3-bit-select result multiplexer. Each cycle it may capture the selected 16-bit result together with the select code that produced it, and derive zero and negative flags at capture time. It holds up to DEPTH entries and presents them in order to the consumer over a valid/ready handshake, so a stalled consumer never loses an ALU result.

## Interface
- WIDTH, 16, result width in bits.
- DEPTH, 4, number of entries; power of two, at least 2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- flush  in  1  synchronous clear of all entries; has priority over push and pop.
- in_valid  in  1  upstream offers in_result/in_sel this cycle.
- in_ready  out  1  buffer can accept; equals !full.
- in_result  in  WIDTH  selected ALU result from the mux.
- in_sel  in  3  select code used for in_result.
- out_valid  out  1  head entry available; equals !empty.
- out_ready  in  1  consumer takes the head entry this cycle.
- out_result  out  WIDTH  head entry result.
- out_sel  out  3  head entry select code.
- out_zero  out  1  head entry result == 0.
- out_neg  out  1  head entry result[WIDTH-1].
- count  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH.

## Operation
- Storage: circular array of DEPTH entries of {result, sel, zero, neg}; write pointer, read pointer, occupancy counter.
- Push = in_valid && in_ready. On push, write the entry at wr_ptr, then wr_ptr+1 mod DEPTH.
- Pop = out_valid && out_ready. On pop, rd_ptr+1 mod DEPTH.
- Flags are computed from in_result at push time and stored; they are never recomputed on read.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Full (count == DEPTH): in_ready = 0. Offers are not accepted even when a pop happens in the same cycle; no bypass.
- Empty (count == 0): out_valid = 0. A push into an empty buffer is not visible until the next cycle; no fall-through.
- Push and pop in the same cycle at 0 < count < DEPTH: both take effect and count is unchanged.
- Pointers wrap modulo DEPTH. Ordering is strictly FIFO across the wrap.
- flush = 1: pointers and count go to 0 next cycle. Any push or pop in that cycle is discarded.
- out_* data fields are read combinationally from mem[rd_ptr]. When out_valid = 0 their value is don't-care; verification must not check them then.
- in_ready and out_valid are decoded from count only. They have no combinational path from in_valid or out_ready.
- Upstream must hold in_result/in_sel stable while in_valid = 1 and in_ready = 0. The buffer does not check this.

## Timing
- Reset (rst_n = 0 at a rising edge): count = 0, pointers = 0, out_valid = 0, in_ready = 1. Storage contents are not reset.
- Reset asserted mid-operation: all entries are dropped at that edge, identical to flush. Reset has priority over flush.
- Latency: an entry pushed at edge N is on out_* with out_valid = 1 after edge N (first pop possible at edge N+1).
- Throughput: one push and one pop per cycle in steady state when not full and not empty.
- count, in_ready and out_valid all change only at rising edges.

## Test plan
- Reset, then push 0x0000/sel 3'b010 -> count 1, out_valid 1, out_result 0x0000, out_zero 1, out_neg 0, out_sel 3'b010 after one edge.
- Push 0x8001, 0x1234, 0xFFFF, 0x0005 with out_ready = 0 -> count 4, in_ready 0. A fifth offer of 0x7777 is held off. Popping then yields the four values in order, with neg flags 1,0,1,0.
- Continuous push/pop with out_ready = 1 for 10 values 0x0001..0x000A -> count stays at 1, pointers wrap twice, output order is exact.
- Full buffer with in_valid = 1 and out_ready = 1 in the same cycle -> one pop only, count 3, in_ready 1 next cycle, offered value accepted the following cycle.
- count = 3 with flush = 1 and in_valid = 1 in the same cycle -> count 0, out_valid 0, offered value discarded.
- rst_n = 0 while count = 2 -> count 0, in_ready 1, out_valid 0 next cycle. A later push of 0x00FF is read back correctly.
